prog_loader: RTL

- Upstream of the 64 KiB synchronous program/data memory; sits between a byte-stream source (UART receiver) and the memory port.
- Parses a framed download, writes the payload into memory, then hands the memory port to the CPU and releases it from hold.
- Memory port contract: single write-enable, 16-bit address, write in one cycle, so one byte per cycle is sustainable.

---
 rtl/prog_loader.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// prog_loader: parses a framed byte-stream download and writes its payload
// into the 64 KiB program memory, then hands the memory port to the CPU.
//
// Frame: SYNC, ADDR_LO, ADDR_HI, LEN_LO, LEN_HI, LEN data bytes, CHK.
// A frame is good when the 8-bit sum of the data bytes plus CHK is zero.
// Each accepted data byte becomes a one-cycle memory write on the cycle after
// its handshake, so a byte per cycle is sustained. After a good frame the
// loader parks in DONE, releases CpuHold and muxes the CPU onto the memory
// port until the next reset.
module prog_loader #(
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int unsigned TIMEOUT   = 1000000
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic [7:0]  RxData,
  input  logic        RxValid,
  output logic        RxReady,
  input  logic [15:0] CpuAddress,
  input  logic        CpuWE,
  input  logic [7:0]  CpuDataOut,
  output logic [15:0] MemAddress,
  output logic        MemWE,
  output logic [7:0]  MemDataIn,
  output logic        CpuHold,
  output logic        Done,
  output logic        Error
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR_LO = 3'd1,
    ST_ADDR_HI = 3'd2,
    ST_LEN_LO  = 3'd3,
    ST_LEN_HI  = 3'd4,
    ST_DATA    = 3'd5,
    ST_CHECK   = 3'd6,
    ST_DONE    = 3'd7
  } state_t;

  // A zero TIMEOUT disables the inter-byte watchdog entirely.
  localparam bit          TIMEOUT_EN = (TIMEOUT != 32'd0);
  // The counter aborts on the edge where it would reach TIMEOUT idle cycles.
  localparam logic [31:0] IDLE_LAST  = TIMEOUT_EN ? 32'(TIMEOUT - 32'd1) : 32'd0;

  // 8-bit modular addition used for the running checksum.
  function automatic logic [7:0] add8(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction

  state_t      state_r;
  state_t      state_s;
  logic [15:0] addr_r;
  logic [15:0] len_r;
  logic [7:0]  sum_r;
  logic [31:0] idle_r;
  logic        wr_en_r;
  logic [15:0] wr_addr_r;
  logic [7:0]  wr_data_r;
  logic        hold_r;
  logic        done_r;
  logic        error_r;
  logic        ready_r;

  logic        hs_s;
  logic        sync_s;
  logic        in_frame_s;
  logic        timeout_s;
  logic        data_hs_s;
  logic        chk_ok_s;
  logic        err_set_s;
  logic        err_clr_s;
  logic [15:0] len_full_s;

  assign hs_s       = RxValid && ready_r;
  assign sync_s     = (RxData == SYNC_BYTE);
  assign in_frame_s = (state_r != ST_IDLE) && (state_r != ST_DONE);
  assign timeout_s  = TIMEOUT_EN && in_frame_s && !hs_s && (idle_r == IDLE_LAST);
  assign data_hs_s  = hs_s && (state_r == ST_DATA);
  assign chk_ok_s   = (add8(sum_r, RxData) == 8'h00);
  assign len_full_s = {RxData, len_r[7:0]};
  // Only a SYNC seen while idle starts a frame; inside a frame it is payload.
  assign err_clr_s  = hs_s && (state_r == ST_IDLE) && sync_s;

  // Next-state decode: the watchdog overrides everything inside a frame.
  always_comb begin
    state_s   = state_r;
    err_set_s = 1'b0;
    if (timeout_s) begin
      state_s   = ST_IDLE;
      err_set_s = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (hs_s && sync_s) state_s = ST_ADDR_LO;
          else                state_s = ST_IDLE;
        end
        ST_ADDR_LO: begin
          if (hs_s) state_s = ST_ADDR_HI;
          else      state_s = ST_ADDR_LO;
        end
        ST_ADDR_HI: begin
          if (hs_s) state_s = ST_LEN_LO;
          else      state_s = ST_ADDR_HI;
        end
        ST_LEN_LO: begin
          if (hs_s) state_s = ST_LEN_HI;
          else      state_s = ST_LEN_LO;
        end
        ST_LEN_HI: begin
          if (hs_s) state_s = (len_full_s != 16'd0) ? ST_DATA : ST_CHECK;
          else      state_s = ST_LEN_HI;
        end
        ST_DATA: begin
          if (hs_s && (len_r == 16'd1)) state_s = ST_CHECK;
          else                          state_s = ST_DATA;
        end
        ST_CHECK: begin
          if (hs_s) begin
            if (chk_ok_s) begin
              state_s = ST_DONE;
            end else begin
              state_s   = ST_IDLE;
              err_set_s = 1'b1;
            end
          end else begin
            state_s = ST_CHECK;
          end
        end
        ST_DONE: begin
          state_s = ST_DONE;
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (!RESETn) state_r <= ST_IDLE;
    else         state_r <= state_s;
  end

  // Header assembly (little-endian) and per-byte address/length/checksum tracking.
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      addr_r <= 16'h0000;
      len_r  <= 16'h0000;
      sum_r  <= 8'h00;
    end else if (hs_s) begin
      case (state_r)
        ST_IDLE:    sum_r        <= 8'h00;
        ST_ADDR_LO: addr_r[7:0]  <= RxData;
        ST_ADDR_HI: addr_r[15:8] <= RxData;
        ST_LEN_LO:  len_r[7:0]   <= RxData;
        ST_LEN_HI:  len_r[15:8]  <= RxData;
        ST_DATA: begin
          addr_r <= addr_r + 16'd1;
          len_r  <= len_r - 16'd1;
          sum_r  <= add8(sum_r, RxData);
        end
        default: begin
        end
      endcase
    end
  end

  // One-cycle write pulse registered from the data-byte handshake; reset kills a pending write.
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      wr_en_r   <= 1'b0;
      wr_addr_r <= 16'h0000;
      wr_data_r <= 8'h00;
    end else begin
      wr_en_r <= data_hs_s;
      if (data_hs_s) begin
        wr_addr_r <= addr_r;
        wr_data_r <= RxData;
      end
    end
  end

  // Inter-byte idle counter: runs only inside a frame and clears on every handshake.
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      idle_r <= 32'd0;
    end else if (TIMEOUT_EN && in_frame_s && !hs_s && !timeout_s) begin
      idle_r <= idle_r + 32'd1;
    end else begin
      idle_r <= 32'd0;
    end
  end

  // Status flags and memory ownership, registered from the next state.
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      hold_r  <= 1'b1;
      done_r  <= 1'b0;
      ready_r <= 1'b1;
      error_r <= 1'b0;
    end else begin
      hold_r  <= (state_s != ST_DONE);
      done_r  <= (state_s == ST_DONE);
      ready_r <= (state_s != ST_DONE);
      if (err_set_s)      error_r <= 1'b1;
      else if (err_clr_s) error_r <= 1'b0;
      else                error_r <= error_r;
    end
  end

  assign RxReady = ready_r;
  assign CpuHold = hold_r;
  assign Done    = done_r;
  assign Error   = error_r;

  // While held, the CPU has no path to the memory write enable.
  assign MemAddress = hold_r ? wr_addr_r : CpuAddress;
  assign MemWE      = hold_r ? wr_en_r   : CpuWE;
  assign MemDataIn  = hold_r ? wr_data_r : CpuDataOut;

endmodule
